// File: rtl/k2red_pipe.sv
// k2red_pipe: 5-stage K2-RED modular reduction, out_c = k^2 * in_a (mod q), k = 2^k1 - 2^k2.
// Build macro K2RED_SIGNED_CORR_EN selects full signed final correction plus the out_err range flag.
module k2red_pipe #(
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*W-1:0]       in_a,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [W-1:0]         q,
  input  logic [$clog2(W):0]   k1,
  input  logic [$clog2(W):0]   k2,
  input  logic [$clog2(W):0]   m,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_c,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
);

  localparam int unsigned AW  = 2 * W;
  localparam int unsigned C1W = 2 * W + 2;
  localparam int unsigned C2W = W + 3;

  // Stage valids: [0]=S1 .. [3]=S4; S5 is the output register set.
  logic [3:0]              vld_q;
  logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q, tag4_q;
  logic [W-1:0]            al_q;
  logic [AW-1:0]           ah_q;
  logic signed [C1W-1:0]   c1_q;
  logic [W-1:0]            c1l_q;
  logic signed [C2W-1:0]   c1h_q;
  logic signed [C2W-1:0]   c2_q;
  logic                    out_valid_q;
  logic [W-1:0]            out_c_q;
  logic [TAG_W-1:0]        out_tag_q;
  logic                    out_err_q;

  logic                    stall;
  logic [AW-1:0]           mask_a;
  logic [W-1:0]            mask_w;
  logic [W-1:0]            al_d;
  logic [AW-1:0]           ah_d;
  logic signed [C1W-1:0]   c1_d;
  logic [W-1:0]            c1l_d;
  logic signed [C2W-1:0]   c1h_d;
  logic signed [C2W-1:0]   c2_d;
  logic signed [C2W-1:0]   qx;
  logic [W-1:0]            c_d;
  logic                    err_d;
`ifdef K2RED_SIGNED_CORR_EN
  logic signed [C2W-1:0]   qx2;
`endif

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Datapath for all five stages; registers below only sample these.
  always_comb begin
    mask_a = ~({AW{1'b1}} << m);
    mask_w = ~({W{1'b1}} << m);
    al_d   = W'(in_a & mask_a);
    ah_d   = in_a >> m;
    c1_d   = (C1W'(al_q) << k1) - (C1W'(al_q) << k2) - C1W'(ah_q);
    c1l_d  = W'(c1_q) & mask_w;
    c1h_d  = C2W'(c1_q >>> m);
    c2_d   = (C2W'(c1l_q) << k1) - (C2W'(c1l_q) << k2) - c1h_q;
    qx     = C2W'(q);
    c_d    = W'(c2_q);
    err_d  = 1'b0;
`ifdef K2RED_SIGNED_CORR_EN
    qx2    = qx <<< 1;
    if (c2_q[C2W-1]) begin
      c_d = W'(c2_q + qx);
    end else if (c2_q >= qx) begin
      c_d = W'(c2_q - qx);
    end
    err_d  = (c2_q < -qx) || (c2_q >= qx2);
`else
    // Legacy: single signed subtract; negative values leave truncated.
    if (c2_q >= qx) begin
      c_d = W'(c2_q - qx);
    end
`endif
  end

  // Whole pipe advances together unless the output is blocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      tag3_q      <= '0;
      tag4_q      <= '0;
      al_q        <= '0;
      ah_q        <= '0;
      c1_q        <= '0;
      c1l_q       <= '0;
      c1h_q       <= '0;
      c2_q        <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (!stall) begin
      vld_q       <= {vld_q[2:0], in_valid};
      tag1_q      <= in_tag;
      tag2_q      <= tag1_q;
      tag3_q      <= tag2_q;
      tag4_q      <= tag3_q;
      al_q        <= al_d;
      ah_q        <= ah_d;
      c1_q        <= c1_d;
      c1l_q       <= c1l_d;
      c1h_q       <= c1h_d;
      c2_q        <= c2_d;
      out_valid_q <= vld_q[3];
      out_c_q     <= c_d;
      out_tag_q   <= tag4_q;
      out_err_q   <= vld_q[3] & err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_k2red_pipe.sv
// Self-checking bench for k2red_pipe with W=32, q=3*2^30+1 (k1=2, k2=0, m=30, k^2=9).
module tb_k2red_pipe;

  localparam int unsigned W     = 32;
  localparam int unsigned TAG_W = 8;
  localparam logic [W-1:0] Q    = 32'd3221225473;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [2*W-1:0]      in_a;
  logic [TAG_W-1:0]    in_tag;
  logic [W-1:0]        q;
  logic [$clog2(W):0]  k1, k2, m;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_c;
  logic [TAG_W-1:0]    out_tag;
  logic                out_err;

  k2red_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_tag(in_tag),
    .q(q), .k1(k1), .k2(k2), .m(m),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  tag;
    logic [31:0] c;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] c;
    logic [7:0]  tag;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   nres   = 0;
  exp_t sb[$];
  logic stall_chk = 1'b0;
  logic [31:0] snap_c;
  logic [7:0]  snap_tag;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] ref9(input logic [63:0] a);
    logic [71:0] t;
    t = 72'(a) * 72'd9;
    return 32'(t % 72'(Q));
  endfunction

  // Pre-correction value for the bench parameters; used only to pick stimuli both builds reduce fully.
  function automatic longint c2_of(input logic [63:0] a);
    longint mask, al, ah, c1, c1l, c1h;
    mask = 64'h3FFF_FFFF;
    al   = longint'(a & 64'h3FFF_FFFF);
    ah   = longint'(a >> 30);
    c1   = 3 * al - ah;
    c1l  = c1 & mask;
    c1h  = c1 >>> 30;
    return 3 * c1l - c1h;
  endfunction

  function automatic logic [63:0] gen_a();
    logic [63:0] a;
    longint      c2;
    a = 64'd1;
    for (int t = 0; t < 100; t++) begin
      a  = {$urandom, $urandom} & 64'h3FFF_FFFF_FFFF_FFFF;
      c2 = c2_of(a);
      if (c2 >= 0 && c2 < 2 * longint'(Q)) break;
    end
    return a;
  endfunction

  // One clock of streaming: score the output being offered, then offer an input.
  task automatic step(input logic iv, input logic [63:0] a, input logic [7:0] tag,
                      input logic ordy, output logic acc);
    exp_t e;
    in_valid  = iv;
    in_a      = a;
    in_tag    = tag;
    out_ready = ordy;
    #1;
    if (stall_chk) begin
      chk("stall_in_ready", 0, in_ready, 0);
      chk("stall_valid", 0, out_valid, 1);
      chk("stall_c", 0, out_c, snap_c);
      chk("stall_tag", 0, out_tag, snap_tag);
    end
    if (out_valid && out_ready) begin
      nres++;
      if (sb.size() == 0) begin
        chk("spurious", nres, out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("stream_c", nres, out_c, e.c);
        chk("stream_tag", nres, out_tag, e.tag);
        chk("stream_err", nres, out_err, 0);
      end
    end
    acc = iv && in_ready;
    if (acc) sb.push_back('{c: ref9(a), tag: tag});
    @(posedge clk); #1;
  endtask

  task automatic single(input vec_t v, input int idx);
    int lat;
    in_valid  = 1'b1;
    in_a      = v.a;
    in_tag    = v.tag;
    out_ready = 1'b1;
    #1;
    chk("single_in_ready", idx, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", idx, lat, 4);
    chk("single_c", idx, out_c, v.c);
    chk("single_tag", idx, out_tag, v.tag);
    chk("single_err", idx, out_err, v.err);
    @(posedge clk); #1;
    chk("single_drained", idx, out_valid, 0);
  endtask

  task automatic drain(input string name);
    logic acc;
    int   guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step(1'b0, 64'd0, 8'd0, 1'b1, acc);
      guard++;
    end
    chk(name, 0, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    logic        acc;
    int          cyc, got, base;
    logic [63:0] a;

    vecs[0] = '{a: 64'd1,                     tag: 8'h11, c: 32'd9,          err: 1'b0};
    vecs[1] = '{a: 64'd3221225473,            tag: 8'h22, c: 32'd0,          err: 1'b0};
    vecs[2] = '{a: 64'd0,                     tag: 8'h33, c: 32'd0,          err: 1'b0};
    vecs[3] = '{a: 64'h0000_0000_4000_0000,   tag: 8'h44, c: 32'd3221225470, err: 1'b0};
`ifdef K2RED_SIGNED_CORR_EN
    vecs[4] = '{a: 64'h0800_0000_2000_0000,   tag: 8'h55, c: 32'd3221225472, err: 1'b0};
`else
    vecs[4] = '{a: 64'h0800_0000_2000_0000,   tag: 8'h55, c: 32'hFFFF_FFFF,  err: 1'b0};
`endif
    vecs[5] = '{a: 64'd3221225472,            tag: 8'h66, c: 32'd3221225464, err: 1'b0};
    vecs[6] = '{a: 64'h0000_0000_FFFF_FFFF,   tag: 8'h77, c: 32'd3221225452, err: 1'b0};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    q         = Q;
    k1        = 6'd2;
    k2        = 6'd0;
    m         = 6'd30;
    #2;
    chk("rst_valid", 0, out_valid, 0);
    chk("rst_c", 0, out_c, 0);
    chk("rst_tag", 0, out_tag, 0);
    chk("rst_err", 0, out_err, 0);
    chk("rst_in_ready", 0, in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) single(vecs[i], i);

    // Back-to-back stream, one accept per cycle.
    cyc  = 0;
    got  = 0;
    base = nres;
    while (got < 64 && cyc < 200) begin
      a = gen_a();
      step(1'b1, a, 8'($urandom_range(0, 255)), 1'b1, acc);
      if (acc) got++;
      cyc++;
    end
    chk("stream_cycles", 0, cyc, 64);
    drain("stream_drain");
    chk("stream_count", 0, nres - base, 64);

    // Backpressure with a full pipe.
    base = nres;
    for (int i = 0; i < 5; i++) step(1'b1, gen_a(), 8'(8'hA0 + i), 1'b1, acc);
    chk("bp_full_valid", 0, out_valid, 1);
    snap_c    = out_c;
    snap_tag  = out_tag;
    stall_chk = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, gen_a(), 8'(8'hC0 + i), 1'b0, acc);
    stall_chk = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, gen_a(), 8'(8'hD0 + i), 1'b1, acc);
    drain("bp_drain");
    chk("bp_count", 0, nres - base, 8);

    // Reset while operands are in flight.
    for (int i = 0; i < 5; i++) step(1'b1, gen_a(), 8'(8'hE0 + i), 1'b0, acc);
    chk("pre_rst_valid", 0, out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 0, out_valid, 0);
    chk("mid_rst_c", 0, out_c, 0);
    chk("mid_rst_tag", 0, out_tag, 0);
    chk("mid_rst_in_ready", 0, in_ready, 1);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b1;
    base = nres;
    for (int i = 0; i < 10; i++) step(1'b0, 64'd0, 8'd0, 1'b1, acc);
    chk("post_rst_quiet", 0, nres - base, 0);
    single(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
